// File: rtl/aes_subbytes_shiftrows.sv
// aes_subbytes_shiftrows
//   One datapath stage of the AES encryption round. Applies the forward
//   S-box (SubBytes) and/or the row rotation (ShiftRows) to a 128-bit state
//   and registers the result, giving exactly one cycle of latency at one
//   state per clock.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears out_data and out_valid
//   in_valid  qualifies in_data, sub_en and shift_en for one cycle
//   sub_en    1 = apply SubBytes, 0 = bypass
//   shift_en  1 = apply ShiftRows, 0 = bypass
//   in_data   input state, byte k = in_data[127-8k -: 8]
//               byte k is at row k%4, column k/4 (column-major)
//   out_data  registered result, same byte ordering as in_data
//   out_valid one-cycle pulse, one cycle after each accepted in_valid
module aes_subbytes_shiftrows (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         sub_en,
  input  logic         shift_en,
  input  logic [127:0] in_data,
  output logic [127:0] out_data,
  output logic         out_valid
);

  // Forward S-box; indexed directly by the input byte value.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Source byte for output byte k under ShiftRows: row r = k%4 rotates left
  // by r, so output (r, c) takes input (r, (c + r) % 4).
  function automatic logic [3:0] shift_src(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = k[3:2];
    return {2'(c + r), r};
  endfunction

  logic [7:0]   byte_p0 [16];
  logic [7:0]   sub_p0  [16];
  logic [7:0]   shr_p0  [16];
  logic [127:0] data_p0;
  logic [127:0] data_p1;
  logic         vld_p1;

  // ---- stage p0: combinational SubBytes then ShiftRows ----
  always_comb begin
    data_p0 = '0;
    for (int k = 0; k < 16; k++) begin
      byte_p0[k] = in_data[127 - 8*k -: 8];
      sub_p0[k]  = sub_en ? sbox_lookup(byte_p0[k]) : byte_p0[k];
    end
    for (int k = 0; k < 16; k++) begin
      shr_p0[k] = shift_en ? sub_p0[shift_src(4'(k))] : sub_p0[k];
      data_p0[127 - 8*k -: 8] = shr_p0[k];
    end
  end

  // ---- stage p1: output register ----
  // Data is only loaded on accepted input so it holds between transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1 <= data_p0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_aes_subbytes_shiftrows.sv
module tb_aes_subbytes_shiftrows;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         sub_en;
  logic         shift_en;
  logic [127:0] in_data;
  logic [127:0] out_data;
  logic         out_valid;

  int n_vec;
  int n_err;

  logic [7:0] ref_sbox [256];

  aes_subbytes_shiftrows dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box derived from first principles: multiplicative inverse then affine map
  function automatic logic [7:0] calc_sbox(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h00;
    if (v != 8'h00) begin
      for (int x = 1; x < 256; x++) begin
        if (gmul(v, 8'(x)) == 8'h01) inv = 8'(x);
      end
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic se, input logic sh);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [127:0] r;
    int           row, col;
    for (int k = 0; k < 16; k++) begin
      b[k] = d[127 - 8*k -: 8];
      if (se) b[k] = ref_sbox[b[k]];
    end
    for (int k = 0; k < 16; k++) begin
      row = k % 4;
      col = k / 4;
      o[k] = sh ? b[row + 4*((col + row) % 4)] : b[k];
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = o[k];
    return r;
  endfunction

  task automatic test_reset;
    reset    = 1'b1;
    in_valid = 1'b1;
    sub_en   = 1'b1;
    shift_en = 1'b1;
    in_data  = {128{1'b1}};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_data !== 128'h0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: out_data=%h out_valid=%b, required 0/0", i, out_data, out_valid);
      end
    end
    reset    = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    in_data  = 128'h000102030405060708090a0b0c0d0e0f;
    @(posedge clk); #1;
    n_vec++;
    if (out_data !== 128'h000102030405060708090a0b0c0d0e0f || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: out_data=%h out_valid=%b, required 000102030405060708090a0b0c0d0e0f/1", out_data, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sub_only;
    in_valid = 1'b1;
    sub_en   = 1'b1;
    shift_en = 1'b0;
    in_data  = 128'h00000000000000000000000000000053;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_data !== 128'h636363636363636363636363636363ed || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sub_only: out_data=%h out_valid=%b, required 636363636363636363636363636363ed/1", out_data, out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sub_only_pulse: out_valid=%b, required 0", out_valid);
    end
    in_valid = 1'b1;
    in_data  = 128'h01ff0001ff0001ff0001ff0001ff0053;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_data !== 128'h7c16637c16637c16637c16637c1663ed) begin
      n_err++;
      $display("FAIL sub_only_mixed: out_data=%h, required 7c16637c16637c16637c16637c1663ed", out_data);
    end
  endtask

  task automatic test_shift_only;
    in_valid = 1'b1;
    sub_en   = 1'b0;
    shift_en = 1'b1;
    in_data  = 128'h000102030405060708090a0b0c0d0e0f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_data !== 128'h00050a0f04090e03080d02070c01060b || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL shift_only: out_data=%h out_valid=%b, required 00050a0f04090e03080d02070c01060b/1", out_data, out_valid);
    end
  endtask

  task automatic test_both;
    in_valid = 1'b1;
    sub_en   = 1'b1;
    shift_en = 1'b1;
    in_data  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    @(posedge clk); #1;
    n_vec++;
    if (out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL both_fips: out_data=%h out_valid=%b, required d4bf5d30e0b452aeb84111f11e2798e5/1", out_data, out_valid);
    end
    shift_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_data !== 128'hd42711aee0bf98f1b8b45de51e415230 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sub_fips: out_data=%h out_valid=%b, required d42711aee0bf98f1b8b45de51e415230/1", out_data, out_valid);
    end
  endtask

  task automatic test_bypass_hold;
    in_valid = 1'b1;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    in_data  = 128'h0123456789abcdef0123456789abcdef;
    @(posedge clk); #1;
    n_vec++;
    if (out_data !== 128'h0123456789abcdef0123456789abcdef || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bypass: out_data=%h out_valid=%b, required 0123456789abcdef0123456789abcdef/1", out_data, out_valid);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      sub_en   = 1'(i);
      shift_en = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (out_data !== 128'h0123456789abcdef0123456789abcdef || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: out_data=%h out_valid=%b, required 0123456789abcdef0123456789abcdef/0", i, out_data, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] exp;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      sub_en   = 1'b1;
      shift_en = 1'(k % 2);
      for (int j = 0; j < 16; j++) in_data[127 - 8*j -: 8] = 8'(k*16 + j);
      exp = model(in_data, 1'b1, 1'(k % 2));
      @(posedge clk); #1;
      n_vec++;
      if (out_data !== exp || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL sweep[%0d]: out_data=%h out_valid=%b, required %h/1", k, out_data, out_valid, exp);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_end: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    in_valid = 1'b1;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    @(posedge clk); #1;
    in_data  = 128'h11111111222222223333333344444444;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (out_data !== 128'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: out_data=%h out_valid=%b, required 0/0", out_data, out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_data !== 128'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dominates: out_data=%h out_valid=%b, required 0/0", out_data, out_valid);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      n_err++;
      $display("FAIL post_reset_idle: out_data=%h out_valid=%b, required 0/0", out_data, out_valid);
    end
    in_valid = 1'b1;
    shift_en = 1'b1;
    in_data  = 128'h000102030405060708090a0b0c0d0e0f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_data !== 128'h00050a0f04090e03080d02070c01060b || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_first: out_data=%h out_valid=%b, required 00050a0f04090e03080d02070c01060b/1", out_data, out_valid);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    in_data  = '0;
    for (int v = 0; v < 256; v++) ref_sbox[v] = calc_sbox(8'(v));
    test_reset;
    test_sub_only;
    test_shift_only;
    test_both;
    test_bypass_hold;
    test_back_to_back;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_shiftrows.md
Name: aes_subbytes_shiftrows

Overview:
Datapath stage of the AES-128/192/256 encryption round that applies SubBytes and/or ShiftRows to a 128-bit state. It is driven by the AES control FSM and returns the transformed state one clock later. Each transform has its own enable, so the FSM can run SubBytes only, ShiftRows only, both, or neither.

Parameters:
None. All widths are fixed: 128-bit state, 8-bit bytes, 16 bytes.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_data, sub_en and shift_en for one cycle
sub_en  input  1  1 = apply SubBytes (forward S-box); 0 = bypass
shift_en  input  1  1 = apply ShiftRows; 0 = bypass
in_data  input  128  input state; byte k = in_data[127-8k -: 8], k = 0..15
out_data  output  128  registered result; same byte ordering as in_data
out_valid  output  1  high for exactly one cycle after each accepted in_valid

Behaviour:
- Reset: reset is asynchronous and active-high. While reset is high, out_data = 128'h0 and out_valid = 0. Reset dominates any simultaneous in_valid.
- Byte/state mapping: byte k sits at row r = k mod 4 and column c = k div 4 (FIPS-197 column-major). Byte 0 is the MSB byte of the bus, i.e. the first byte shifted in serially by the controller.
- SubBytes: each of the 16 bytes is replaced independently by the FIPS-197 forward S-box value. Examples: 00->63, 01->7C, 53->ED, FF->16. The S-box is a 256-entry combinational lookup (case or ROM), replicated 16 times. Only the forward table is implemented; there is no inverse.
- ShiftRows: output byte (r + 4c) = input byte (r + 4*((c + r) mod 4)). Row 0 is unchanged. Rows 1, 2 and 3 rotate left by 1, 2 and 3 bytes. This is pure wiring with no logic.
- Order when both are enabled: SubBytes is applied first, then ShiftRows. The two operations commute, so the result is the same either way.
- sub_en = 0 and shift_en = 0: the state passes through unchanged, with the same 1-cycle latency.
- Timing: on a rising clk edge with in_valid = 1, out_data <= f(in_data, sub_en, shift_en) and out_valid <= 1.
- On a rising clk edge with in_valid = 0, out_data holds its value and out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is 1 state per cycle, so back-to-back in_valid is allowed and produces back-to-back out_valid.
- The enables are sampled only when in_valid = 1. Their values while in_valid = 0 are don't-care.
- Reset mid-stream: any pending result is discarded. After release, the first out_valid occurs 1 cycle after the first in_valid sampled with reset low.
- There are no X-propagation paths: every one of the 256 byte values maps to a defined S-box output.

Test Plan:
- Reset: hold reset high, drive in_valid = 1 with in_data = all FF -> out_data = 0, out_valid = 0 throughout. Release reset -> outputs update from the next edge.
- SubBytes only: in_data = 00000000000000000000000000000053, sub_en = 1, shift_en = 0 -> next cycle out_data = 636363636363636363636363636363ED, out_valid = 1 for one cycle.
- ShiftRows only: in_data = 000102030405060708090A0B0C0D0E0F, sub_en = 0, shift_en = 1 -> out_data = 00050A0F04090E03080D02070C01060B.
- Both (FIPS-197 Appendix B, round 1): in_data = 193DE3BEA0F4E22B9AC68D2AE9F84808 -> out_data = D4BF5D30E0B452AEB84111F11E2798E5. With sub_en only, the same input -> D42711AEE0BF98F1B8B45DE51E415230.
- Bypass and hold: sub_en = shift_en = 0, in_data = 0123456789ABCDEF0123456789ABCDEF -> identical out_data. Then drop in_valid for 3 cycles -> out_data is held and out_valid = 0.
- Full S-box sweep plus back-to-back: stream 16 consecutive cycles where every byte of in_data equals k*16 + byte index (k = 0..15), so together they cover all 256 byte values. Check against a reference S-box table -> one result per cycle, each 1 cycle late, all bytes correct.
